// File: rtl/float32_accumulator.sv
// Multi-cycle IEEE-754 single-precision accumulator (align/add/normalise FSM).
// Sums a stream of float32 products up to in_last and presents the total with valid/ready.
module float32_accumulator #(
  parameter int unsigned COUNT_W   = 16,
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               out_ready,
  output logic [31:0]        out_result,
  output logic               out_valid,
  input  logic               in_result_ready,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t              state;
  logic [31:0]         acc;
  logic [31:0]         operand;
  logic                last;
  logic [COUNT_W-1:0]  count;

  logic                special;
  logic [31:0]         special_val;
  logic                sign_big;
  logic                sign_small;
  logic [23:0]         man_big;
  logic [23:0]         man_small;
  logic [7:0]          exp_big;

  logic [24:0]         sum;
  logic                sum_sign;

  // ALIGN stage: unpack, detect specials, order by exponent, shift smaller mantissa.
  logic [7:0]  acc_exp, op_exp, exp_diff;
  logic [23:0] acc_man, op_man, small_man, aligned_man;
  logic        acc_nan, op_nan, acc_inf, op_inf, acc_is_big;
  logic        a_special;
  logic [31:0] a_special_val;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_exp     = acc[30:23];
    op_exp      = operand[30:23];
    acc_man     = (acc_exp == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
    op_man      = (op_exp == 8'd0)  ? 24'd0 : {1'b1, operand[22:0]};
    acc_nan     = (acc_exp == 8'hFF) && (acc[22:0] != 23'd0);
    op_nan      = (op_exp == 8'hFF)  && (operand[22:0] != 23'd0);
    acc_inf     = (acc_exp == 8'hFF) && (acc[22:0] == 23'd0);
    op_inf      = (op_exp == 8'hFF)  && (operand[22:0] == 23'd0);
    acc_is_big  = (acc_exp >= op_exp);
    exp_diff    = acc_is_big ? (acc_exp - op_exp) : (op_exp - acc_exp);
    small_man   = acc_is_big ? op_man : acc_man;
    aligned_man = (exp_diff >= 8'd25) ? 24'd0 : (small_man >> exp_diff);

    a_special     = 1'b0;
    a_special_val = 32'd0;
    if (acc_nan || op_nan || (acc_inf && op_inf && (acc[31] != operand[31]))) begin
      a_special     = 1'b1;
      a_special_val = NAN_VALUE;
    end else if (acc_inf) begin
      a_special     = 1'b1;
      a_special_val = acc;
    end else if (op_inf) begin
      a_special     = 1'b1;
      a_special_val = operand;
    end
  end

  // ADD stage: magnitude add or subtract; subtraction takes the sign of the larger magnitude.
  logic [24:0] add_sum;
  logic        add_sign;

  always_comb begin
    add_sum  = 25'd0;
    add_sign = sign_big;
    if (sign_big == sign_small) begin
      add_sum = {1'b0, man_big} + {1'b0, man_small};
    end else if (man_big >= man_small) begin
      add_sum = {1'b0, man_big - man_small};
    end else begin
      add_sum  = {1'b0, man_small - man_big};
      add_sign = sign_small;
    end
  end

  // NORM stage: carry or leading-one normalisation, truncating rounding, range clamps.
  logic [4:0]        lz;
  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;
  logic [31:0]       norm_result;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end
    if (sum[24]) begin
      norm_frac = sum[23:1];
      norm_exp  = $signed({2'b00, exp_big}) + 10'sd1;
    end else begin
      norm_frac = sum[22:0] << lz;
      norm_exp  = $signed({2'b00, exp_big}) - $signed({5'b00000, lz});
    end

    if (special)                  norm_result = special_val;
    else if (sum == 25'd0)        norm_result = 32'd0;
    else if (norm_exp >= 10'sd255) norm_result = {sum_sign, 8'hFF, 23'd0};
    else if (norm_exp <= 10'sd0)  norm_result = 32'd0;
    else                          norm_result = {sum_sign, norm_exp[7:0], norm_frac};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state       <= IDLE;
      acc         <= 32'd0;
      operand     <= 32'd0;
      last        <= 1'b0;
      count       <= '0;
      special     <= 1'b0;
      special_val <= 32'd0;
      sign_big    <= 1'b0;
      sign_small  <= 1'b0;
      man_big     <= 24'd0;
      man_small   <= 24'd0;
      exp_big     <= 8'd0;
      sum         <= 25'd0;
      sum_sign    <= 1'b0;
      out_ready   <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_ready <= 1'b1;
          if (in_valid && out_ready) begin
            operand   <= in_data;
            last      <= in_last;
            if (count != '1) count <= count + COUNT_W'(1);
            out_ready <= 1'b0;
            state     <= ALIGN;
          end
        end
        ALIGN: begin
          special     <= a_special;
          special_val <= a_special_val;
          sign_big    <= acc_is_big ? acc[31] : operand[31];
          sign_small  <= acc_is_big ? operand[31] : acc[31];
          man_big     <= acc_is_big ? acc_man : op_man;
          man_small   <= aligned_man;
          exp_big     <= acc_is_big ? acc_exp : op_exp;
          state       <= ADD;
        end
        ADD: begin
          sum      <= add_sum;
          sum_sign <= add_sign;
          state    <= NORM;
        end
        NORM: begin
          acc <= norm_result;
          if (last) begin
            out_valid  <= 1'b1;
            out_result <= norm_result;
            out_count  <= count;
            state      <= DONE;
          end else begin
            out_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (in_result_ready) begin
            out_valid <= 1'b0;
            acc       <= 32'd0;
            count     <= '0;
            out_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float32_accumulator.sv
// Directed bench for float32_accumulator: table of one/two-term sums plus
// streaming, back-pressure, zero-stall and mid-operation reset sequences.
module tb_float32_accumulator;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_valid;
  logic        in_result_ready;
  logic [15:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  float32_accumulator #(.COUNT_W(16), .NAN_VALUE(32'h7FC00000)) dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_valid       (out_valid),
    .in_result_ready (in_result_ready),
    .out_count       (out_count)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    bit          two;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the operand until accepted, returns at the negedge after acceptance.
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!out_ready && n < 20) begin
      @(negedge in_clk);
      n++;
    end
    check("send out_ready", 32'(out_ready), 32'd1);
    @(negedge in_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge in_clk);
      n++;
    end
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    in_result_ready = 1'b1;
    @(negedge in_clk);
    in_result_ready = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_prev, t_now, n, pulses;

    vecs[0]  = '{"one_plus_two",   1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 16'd2};
    vecs[1]  = '{"cancel",         1'b1, 32'h3FC00000, 32'hBFC00000, 32'h00000000, 16'd2};
    vecs[2]  = '{"overflow_inf",   1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 16'd2};
    vecs[3]  = '{"inf_minus_inf",  1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 16'd2};
    vecs[4]  = '{"truncate_tiny",  1'b1, 32'h3F800000, 32'h30800000, 32'h3F800000, 16'd2};
    vecs[5]  = '{"denormal_flush", 1'b0, 32'h00000000, 32'h00400000, 32'h00000000, 16'd1};
    vecs[6]  = '{"nan_canon",      1'b0, 32'h00000000, 32'h7FC00001, 32'h7FC00000, 16'd1};
    vecs[7]  = '{"three_minus_one",1'b1, 32'h40400000, 32'hBF800000, 32'h40000000, 16'd2};
    vecs[8]  = '{"neg_half",       1'b1, 32'hBF800000, 32'h3F000000, 32'hBF000000, 16'd2};
    vecs[9]  = '{"lsb_shift23",    1'b1, 32'h3F800000, 32'h34000000, 32'h3F800001, 16'd2};
    vecs[10] = '{"inf_plus_one",   1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 16'd2};
    vecs[11] = '{"single_neg_inf", 1'b0, 32'h00000000, 32'hFF800000, 32'hFF800000, 16'd1};

    in_rst_n        = 1'b0;
    in_data         = 32'd0;
    in_valid        = 1'b0;
    in_last         = 1'b0;
    in_result_ready = 1'b0;

    #1;
    check("reset out_valid",  32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_count",  32'(out_count), 32'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    @(negedge in_clk);
    check("post-reset out_ready", 32'(out_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].two) send(vecs[i].a, 1'b0);
      send(vecs[i].b, 1'b1);
      wait_valid(vecs[i].name);
      check({vecs[i].name, " result"}, out_result, vecs[i].res);
      check({vecs[i].name, " count"}, 32'(out_count), 32'(vecs[i].cnt));
      release_result();
    end

    // Nine 1.0 terms with in_valid held high: one acceptance every 4 cycles.
    in_data  = 32'h3F800000;
    in_last  = 1'b0;
    in_valid = 1'b1;
    t_prev   = 0;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      if (k == 8) in_last = 1'b1;
      while (!out_ready && n < 20) begin
        @(negedge in_clk);
        n++;
      end
      check("stream out_ready", 32'(out_ready), 32'd1);
      t_now = cyc;
      if (k > 0) check("stream accept gap", 32'(t_now - t_prev), 32'd4);
      t_prev = t_now;
      @(negedge in_clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_valid("stream");
    check("stream latency", 32'(cyc - t_prev), 32'd4);
    check("stream result", out_result, 32'h41100000);
    check("stream count", 32'(out_count), 32'd9);
    for (int s = 0; s < 5; s++) begin
      @(negedge in_clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_result", out_result, 32'h41100000);
      check("stall out_count", 32'(out_count), 32'd9);
      check("stall out_ready", 32'(out_ready), 32'd0);
    end
    release_result();
    send(32'h40000000, 1'b1);
    wait_valid("after_clear");
    check("after_clear result", out_result, 32'h40000000);
    check("after_clear count", 32'(out_count), 32'd1);
    release_result();

    // Zero-stall: consumer ready before DONE, valid pulse lasts one cycle.
    in_result_ready = 1'b1;
    send(32'h3F800000, 1'b1);
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      if (out_valid) begin
        pulses++;
        check("zero_stall result", out_result, 32'h3F800000);
      end
      @(negedge in_clk);
    end
    check("zero_stall pulse width", 32'(pulses), 32'd1);
    in_result_ready = 1'b0;

    // Asynchronous reset while the operand sits in ADD.
    send(32'h40A00000, 1'b0);
    @(posedge in_clk);
    #2;
    in_rst_n = 1'b0;
    #1;
    check("midreset out_valid",  32'(out_valid), 32'd0);
    check("midreset out_ready",  32'(out_ready), 32'd0);
    check("midreset out_result", out_result, 32'd0);
    check("midreset out_count",  32'(out_count), 32'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    @(negedge in_clk);
    send(32'h40400000, 1'b1);
    wait_valid("post_abort");
    check("post_abort result", out_result, 32'h40400000);
    check("post_abort count", 32'(out_count), 32'd1);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
